// File: rtl/spram_fread_responder_pkg.sv
// Shared definitions for the SPRAM fread responder: FSM encoding and storage geometry.
package spram_fread_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int SPRAM_BYTES       = 32768;
  localparam int SPRAM_AW          = 14;
  localparam int DEFAULT_BURST_LEN = 2048;
  // Wide enough to hold a full-image burst count (32768).
  localparam int CNT_W             = $clog2(SPRAM_BYTES) + 1;

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural stand-in for the iCE40 UltraPlus 16K x 16 single-port RAM primitive.
// Synchronous read and write; DATAOUT holds its value whenever the RAM is not read.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic        active;
  logic [15:0] bit_mask;

  assign active   = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;
  assign bit_mask = {{4{MASKWREN[3]}}, {4{MASKWREN[2]}}, {4{MASKWREN[1]}}, {4{MASKWREN[0]}}};

  // NOTE: storage arrays get no reset; clearing them would need a sequencer and real RAM cannot do it.
  always_ff @(posedge CLOCK) begin
    if (active) begin
      if (WREN) begin
        mem[ADDRESS] <= (DATAIN & bit_mask) | (mem[ADDRESS] & ~bit_mask);
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_byte_port.sv
// Byte-oriented view of one SB_SPRAM256KA: write/read address mux, 16-bit hold register
// and low/high byte select. Out-of-bounds fetches load 0xFFFF without touching the RAM.
module spram_byte_port
  import spram_fread_responder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic                capture,
  input  logic                oob,
  input  logic [SPRAM_AW:0]   byte_addr,
  input  logic                wr_en,
  input  logic [SPRAM_AW-1:0] wr_addr,
  input  logic [15:0]         wr_data,
  output logic [7:0]          rd_byte
);

  logic [15:0]         dout;
  logic [15:0]         hold;
  logic [SPRAM_AW-1:0] addr;

  // Writes only reach here while the responder is idle, so they never collide with a fetch.
  assign addr = wr_en ? wr_addr : byte_addr[SPRAM_AW:1];

  SB_SPRAM256KA u_spram (
    .ADDRESS    (addr),
    .DATAIN     (wr_data),
    .MASKWREN   (4'b1111),
    .WREN       (wr_en),
    .CHIPSELECT (wr_en | (rd_en & ~oob)),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 16'h0000;
    end else if (capture) begin
      hold <= oob ? 16'hFFFF : dout;
    end
  end

  assign rd_byte = byte_addr[0] ? hold[15:8] : hold[7:0];

endmodule

// File: rtl/spram_fread_responder.sv
// Streams BURST_LEN bytes from a 32 KiB SPRAM image starting at a requested byte offset.
// Optional SPRAM_FREAD_BOUNDS_EN: offsets >= 32 KiB read as 0xFF instead of wrapping.
module spram_fread_responder
  import spram_fread_responder_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_offset,
  output logic [7:0]          resp_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_last,
  input  logic                wr_en,
  input  logic [SPRAM_AW-1:0] wr_addr,
  input  logic [15:0]         wr_data,
  output logic                busy
);

  state_t           state, next_state;
  logic             fetch_phase;
  logic [31:0]      cur_offset;
  logic [CNT_W-1:0] remaining;
  logic             rd_en, capture, oob, wr_ok, fire;
  logic [7:0]       rd_byte;

`ifdef SPRAM_FREAD_BOUNDS_EN
  assign oob = (cur_offset >= 32'(SPRAM_BYTES));
`else
  assign oob = 1'b0;
`endif

  // A pending request always wins over the load port.
  assign wr_ok = wr_en && (state == IDLE) && !req_valid;
  assign fire  = resp_valid && resp_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_last  = 1'b0;
    rd_en      = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = FETCH;
      end
      FETCH: begin
        // Phase 0 issues the read, phase 1 captures the registered RAM output.
        rd_en   = !fetch_phase;
        capture = fetch_phase;
        if (fetch_phase) next_state = STREAM;
      end
      STREAM: begin
        resp_valid = 1'b1;
        resp_last  = (remaining == CNT_W'(1));
        if (resp_ready) begin
          if (resp_last)          next_state = IDLE;
          else if (cur_offset[0]) next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign resp_data = resp_valid ? rd_byte : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_phase <= 1'b0;
      cur_offset  <= 32'd0;
      remaining   <= '0;
    end else begin
      state       <= next_state;
      fetch_phase <= (state == FETCH) && !fetch_phase;
      if (state == IDLE && req_valid) begin
        cur_offset <= req_offset;
        remaining  <= CNT_W'(BURST_LEN);
      end else if (fire) begin
        cur_offset <= cur_offset + 32'd1;
        remaining  <= remaining - CNT_W'(1);
      end
    end
  end

  spram_byte_port u_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .capture   (capture),
    .oob       (oob),
    .byte_addr (cur_offset[SPRAM_AW:0]),
    .wr_en     (wr_ok),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_byte   (rd_byte)
  );

endmodule
